// File: rtl/guess_game_ctrl.sv
`timescale 1ns/1ps
// Number-guessing game controller: debounced keys, LFSR-drawn secret digit,
// guess stepping and submission, BCD try counter and hint/win status.
module guess_game_ctrl #(
  parameter logic [19:0] DB_CYCLES = 20'd1000000,
  parameter logic [7:0]  MAX_TRIES = 8'h99,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       KEY_Up,
  input  logic       KEY_Down,
  input  logic       KEY_Ok,
  output logic [3:0] data,
  output logic [7:0] tries,
  output logic [1:0] hint,
  output logic       win
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_PLAY,
    ST_CHECK,
    ST_WIN
  } state_t;

  localparam logic [1:0] HINT_NONE = 2'b00;
  localparam logic [1:0] HINT_LOW  = 2'b01;
  localparam logic [1:0] HINT_HIGH = 2'b10;
  localparam logic [1:0] HINT_OK   = 2'b11;

  localparam int K_UP   = 0;
  localparam int K_DOWN = 1;
  localparam int K_OK   = 2;

  logic [2:0]  key_raw;
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  stable;
  logic [2:0]  press;
  logic [19:0] db_cnt [3];

  logic [7:0]  lfsr;
  logic        lfsr_fb;
  logic [3:0]  secret_draw;
  logic [3:0]  secret;
  state_t      state;

  assign key_raw = {KEY_Ok, KEY_Down, KEY_Up};

  // Keys idle high, so synchronizers and stable levels reset to 1; a key held
  // through reset is then seen as a fresh press once it has debounced.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1  <= '1;
      sync2  <= '1;
      stable <= '1;
      press  <= '0;
      // NOTE: the counter array is ordinary flops, not RAM, so it is reset with everything else.
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      sync1 <= key_raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_CYCLES - 20'd1) begin
          db_cnt[i] <= '0;
          stable[i] <= sync2[i];
          press[i]  <= ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 20'd1;
        end
      end
    end
  end

  // x^8 + x^6 + x^5 + x^4 + 1; a non-zero seed never reaches the all-zero lockup.
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[6:0], lfsr_fb};
  end

  always_comb begin
    // NOTE: default first so every path assigns the variable and no latch is inferred.
    secret_draw = lfsr[3:0];
    if (lfsr[3:0] >= 4'd10) secret_draw = lfsr[3:0] - 4'd10;
  end

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == MAX_TRIES)      return v;
    else if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return v + 8'd1;
  endfunction

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state  <= ST_INIT;
      secret <= '0;
      data   <= '0;
      tries  <= '0;
      hint   <= HINT_NONE;
      win    <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          secret <= secret_draw;
          data   <= '0;
          tries  <= '0;
          hint   <= HINT_NONE;
          win    <= 1'b0;
          state  <= ST_PLAY;
        end
        ST_PLAY: begin
          if (press[K_OK]) begin
            state <= ST_CHECK;
          end else if (press[K_UP]) begin
            data <= (data == 4'd9) ? 4'd0 : data + 4'd1;
          end else if (press[K_DOWN]) begin
            data <= (data == 4'd0) ? 4'd9 : data - 4'd1;
          end
        end
        ST_CHECK: begin
          tries <= bcd_inc(tries);
          if (data < secret) begin
            hint  <= HINT_LOW;
            state <= ST_PLAY;
          end else if (data > secret) begin
            hint  <= HINT_HIGH;
            state <= ST_PLAY;
          end else begin
            hint  <= HINT_OK;
            win   <= 1'b1;
            data  <= secret;
            state <= ST_WIN;
          end
        end
        ST_WIN: begin
          if (press[K_OK]) state <= ST_INIT;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_game_ctrl.sv
`timescale 1ns/1ps
// Directed bench for guess_game_ctrl with DB_CYCLES=4; the secret digit is
// predicted from an LFSR model stepped once per clock since reset release.
module tb_guess_game_ctrl;

  localparam logic [7:0] SEED = 8'hA5;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       KEY_Up = 1'b1;
  logic       KEY_Down = 1'b1;
  logic       KEY_Ok = 1'b1;
  logic [3:0] data;
  logic [7:0] tries;
  logic [1:0] hint;
  logic       win;
  logic [31:0] hint_w;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  assign hint_w = {30'd0, hint};

  guess_game_ctrl #(
    .DB_CYCLES(20'd4),
    .MAX_TRIES(8'h99),
    .LFSR_SEED(SEED)
  ) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .KEY_Up  (KEY_Up),
    .KEY_Down(KEY_Down),
    .KEY_Ok  (KEY_Ok),
    .data    (data),
    .tries   (tries),
    .hint,
    .win     (win)
  );

  always #10 CLK = ~CLK;

  // Clock edges seen since the last reset release.
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_after(input int n);
    logic [7:0] v;
    v = SEED;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  function automatic logic [3:0] secret_of(input logic [7:0] v);
    if (v[3:0] >= 4'd10) return v[3:0] - 4'd10;
    return v[3:0];
  endfunction

  function automatic logic [7:0] bcd_of(input int n);
    int m;
    m = (n > 99) ? 99 : n;
    return {4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [1:0] cmp_code(input int g, input int s);
    if (g < s) return 2'b01;
    if (g > s) return 2'b10;
    return 2'b11;
  endfunction

  // Hold the selected keys low for 8 cycles, then release for 8; the press
  // result (including a CHECK outcome) is settled when this returns.
  task automatic press(input bit up, input bit down, input bit ok, output int start_cyc);
    @(negedge CLK);
    start_cyc = cyc;
    KEY_Up   = ~up;
    KEY_Down = ~down;
    KEY_Ok   = ~ok;
    repeat (8) @(negedge CLK);
    KEY_Up   = 1'b1;
    KEY_Down = 1'b1;
    KEY_Ok   = 1'b1;
    repeat (8) @(negedge CLK);
  endtask

  task automatic ups(input int n);
    int c;
    for (int i = 0; i < n; i++) press(1'b1, 1'b0, 1'b0, c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [3:0] sec;
    int g;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_data", 32'(data), 32'd0);
    check("rst_tries", 32'(tries), 32'h00);
    check("rst_hint", hint_w, 32'd0);
    check("rst_win", 32'(win), 32'd0);
    RSTn = 1'b1;
    repeat (4) @(negedge CLK);
    check("init_data", 32'(data), 32'd0);

    // Short bounces never produce a press
    KEY_Up = 1'b0; repeat (3) @(negedge CLK);
    KEY_Up = 1'b1; repeat (3) @(negedge CLK);
    KEY_Up = 1'b0; repeat (3) @(negedge CLK);
    KEY_Up = 1'b1; repeat (10) @(negedge CLK);
    check("glitch_data", 32'(data), 32'd0);

    // Long hold: one increment, 7 cycles after the key goes low
    KEY_Up = 1'b0;
    repeat (6) @(negedge CLK);
    check("hold_before7", 32'(data), 32'd0);
    @(negedge CLK);
    check("hold_at7", 32'(data), 32'd1);
    repeat (93) @(negedge CLK);
    check("hold_once", 32'(data), 32'd1);
    KEY_Up = 1'b1;
    repeat (10) @(negedge CLK);
    check("release_nopulse", 32'(data), 32'd1);

    // Wrap-around
    press(1'b0, 1'b1, 1'b0, c0);
    check("down_1to0", 32'(data), 32'd0);
    press(1'b0, 1'b1, 1'b0, c0);
    check("down_wrap", 32'(data), 32'd9);
    press(1'b1, 1'b0, 1'b0, c0);
    check("up_wrap", 32'(data), 32'd0);

    // up+ok together: ok wins, guess unchanged, CHECK taken (secret 5)
    press(1'b1, 1'b0, 1'b1, c0);
    check("upok_data", 32'(data), 32'd0);
    check("upok_tries", 32'(tries), 32'h01);
    check("upok_hint", hint_w, 32'd1);
    check("upok_win", 32'(win), 32'd0);

    // Reach data=7, tries=05, then reset asynchronously mid-cycle
    ups(7);
    check("pre_rst_data", 32'(data), 32'd7);
    for (int i = 0; i < 4; i++) press(1'b0, 1'b0, 1'b1, c0);
    check("pre_rst_tries", 32'(tries), 32'h05);
    check("pre_rst_hint", hint_w, 32'd2);
    @(negedge CLK);
    #3 RSTn = 1'b0;
    #1;
    check("async_data", 32'(data), 32'd0);
    check("async_tries", 32'(tries), 32'h00);
    check("async_hint", hint_w, 32'd0);
    check("async_win", 32'(win), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    // Guess sequence against secret 5
    ups(2);
    press(1'b0, 1'b0, 1'b1, c0);
    check("g2_hint", hint_w, 32'd1);
    check("g2_tries", 32'(tries), 32'h01);
    ups(6);
    press(1'b0, 1'b0, 1'b1, c0);
    check("g8_hint", hint_w, 32'd2);
    check("g8_tries", 32'(tries), 32'h02);
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0, c0);
    press(1'b0, 1'b0, 1'b1, c0);
    check("g5_hint", hint_w, 32'd3);
    check("g5_win", 32'(win), 32'd1);
    check("g5_tries", 32'(tries), 32'h03);
    check("g5_data", 32'(data), 32'd5);

    // In WIN, up is ignored
    press(1'b1, 1'b0, 1'b0, c0);
    check("win_up_data", 32'(data), 32'd5);
    check("win_up_win", 32'(win), 32'd1);
    check("win_up_tries", 32'(tries), 32'h03);

    // New round; secret is drawn on the 8th edge after ok goes low
    press(1'b0, 1'b0, 1'b1, c0);
    sec = secret_of(lfsr_after(c0 + 7));
    check("nr_win", 32'(win), 32'd0);
    check("nr_tries", 32'(tries), 32'h00);
    check("nr_hint", hint_w, 32'd0);
    check("nr_data", 32'(data), 32'd0);
    ups(int'(sec));
    press(1'b0, 1'b0, 1'b1, c0);
    check("nr_secret_hint", hint_w, 32'd3);
    check("nr_secret_win", 32'(win), 32'd1);
    check("nr_secret_data", 32'(data), 32'(sec));

    // Another round for BCD carry and saturation
    press(1'b0, 1'b0, 1'b1, c0);
    sec = secret_of(lfsr_after(c0 + 7));
    g = (int'(sec) + 1) % 10;
    ups(g);
    for (int n = 1; n <= 130; n++) begin
      if (n == 121) begin
        ups(8);
        g = (int'(sec) + 9) % 10;
      end
      press(1'b0, 1'b0, 1'b1, c0);
      check($sformatf("sat_tries_%0d", n), 32'(tries), 32'(bcd_of(n)));
      check($sformatf("sat_hint_%0d", n), hint_w, 32'(cmp_code(g, int'(sec))));
    end
    check("sat_win", 32'(win), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
